sm_chain_sched: RTL and testbench
=================================

# sm_chain_sched

Sequencer for a chain of NUM_STAGES windowed processing stages built on the codebase's first/window/last stage protocol. It accepts blocks from an upstream source through a req/ack handshake and issues each stage's `first` pulse and window. It advances a block from stage i to stage i+1 when stage i finishes, and holds the chain when the sink applies backpressure. It sits between the block source and the stage datapath, replacing hand-wired first→last chaining.

## Interface
- NUM_STAGES, 4: stages in the chain; range 1..15.
- WIDTH, 8: per-stage window counter width.
- MOD_COUNT, 14: terminal count. Window = MOD_COUNT+1 enabled cycles, with one load cycle. Range 1 ≤ MOD_COUNT < 2^WIDTH.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- clk_ena  in  1  clock enable; all state updates are qualified by it, except rst.
- abort  in  1  flush all stages; effective on enabled cycles.
- start_req  in  1  upstream has a block (level).
- start_ack  out  1  block accepted into stage 0 this cycle.
- sink_ready  in  1  downstream can take the block leaving the last stage.
- first  out  NUM_STAGES  per-stage load pulse (stage counter = 0).
- windows  out  NUM_STAGES  per-stage active window.
- last  out  NUM_STAGES  per-stage terminal cycle (counter = MOD_COUNT).
- done  out  1  block leaves last stage this cycle.
- occupancy  out  4  number of active stages.
- busy  out  1  occupancy ≠ 0.

## Operation
- Per stage i, state: active a[i] and counter c[i] (WIDTH bits).
- Decoded outputs:
  - windows[i] = a[i].
  - first[i] = a[i] & (c[i]==0).
  - last[i] = a[i] & (c[i]==MOD_COUNT).
  - occupancy = popcount(a).
  - busy = |a.
- Advance terms (combinational):
  - adv[N-1] = last[N-1] & sink_ready.
  - adv[i] = last[i] & (~a[i+1] | adv[i+1]).
- start_ack = start_req & clk_ena & ~rst & ~abort & (~a[0] | adv[0]).
- done = adv[N-1] & clk_ena & ~rst & ~abort.
- Stage 0 update, enabled cycle: if start_ack, then a[0]=1, c[0]=0. Else if adv[0], then a[0]=0.
- Stage i>0 update, enabled cycle: if adv[i-1], then a[i]=1, c[i]=0. Else if adv[i], then a[i]=0.
- Counting: an active stage with c<MOD_COUNT increments c by 1. An active stage at MOD_COUNT with adv=0 holds (stall); c never wraps.
- Back-to-back: a load and an unload of the same stage in one cycle resolve to load.
- abort on an enabled cycle: all a=0, c=0 at the next edge. No ack and no done in that cycle.
- rst at an edge: all a=0, c=0 regardless of clk_ena. start_ack=0 and done=0 while rst is high.
- clk_ena low: all state frozen. first/last/windows hold their values, so consumers qualify them with clk_ena. start_ack=0 and done=0.
- Outputs first/last/windows/occupancy/busy derive from registers only. start_ack/done have comb paths from start_req/sink_ready/clk_ena/abort.

## Timing
- Reset values: first=0, windows=0, last=0, occupancy=0, busy=0. start_ack=0 and done=0 while rst is high.
- Ack at enabled cycle t: first[0] and windows[0] at t+1; last[0] at t+1+MOD_COUNT.
- Stage hand-off: last[i] with adv[i] at cycle u gives first[i+1] at u+1.
- Latency, no stall and clk_ena=1: done at ack+N·(MOD_COUNT+1) cycles.
- Max throughput: one ack per MOD_COUNT+1 cycles. The next ack coincides with last[0].
- Stall release: once sink_ready rises, done and the upstream hand-offs fire in the same cycle along the whole stalled chain.

## Test plan
- Reset: rst high for 3 cycles with start_req=1 and clk_ena=1 -> start_ack=0 throughout. After rst all outputs 0. First ack on the cycle after rst drops.
- Single block (N=4, M=3, clk_ena=1, sink_ready=1), ack at cycle 0:
  - windows[0]=1 for cycles 1–4; last[0] at 4.
  - first[1] at 5, first[2] at 9, first[3] at 13.
  - done at 16; occupancy 0 at 17.
- Back-to-back, start_req held high:
  - acks at 0, 4, 8, 12, 16…
  - occupancy reaches 4 at cycle 13.
  - done at 16, 20, 24…
- Backpressure: full pipe, sink_ready=0 from cycle 15.
  - last[3] held, c[3]=3; stages 0–2 stall at last; start_ack=0.
  - sink_ready=1 at cycle 30 -> done and all hand-offs at 30; first[1..3] at 31.
- clk_ena alternating 1/0, single block: every event of the single-block scenario lands on enabled cycles only, at twice the time. No state change and no ack/done on disabled cycles.
- Abort at cycle 7 with 2 blocks in flight and start_req=1 -> no ack at 7. Windows=0 and occupancy=0 at 8; no done ever for those blocks. A new ack at cycle 8.

Source files
------------

// File: rtl/sm_chain_sched_if.sv
// Handshake and stage-decode bundle for sm_chain_sched.
//
// Signals
//   clk_ena     enable; qualifies every state update of the sequencer
//   abort       flush all stages (effective on enabled cycles)
//   start_req   upstream has a block (level)
//   start_ack   block accepted into stage 0 this cycle
//   sink_ready  downstream can take the block leaving the last stage
//   first       per-stage load pulse (stage counter == 0)
//   windows     per-stage active window
//   last        per-stage terminal cycle (counter == MOD_COUNT)
//   done        block leaves the last stage this cycle
//   occupancy   number of active stages
//   busy        occupancy != 0
//
// Modports
//   master  the sequencer side
//   slave   the environment side (block source, sink, stage datapath)
interface sm_chain_sched_if #(
    parameter int unsigned NUM_STAGES = 4
);
    logic                  clk_ena;
    logic                  abort;
    logic                  start_req;
    logic                  start_ack;
    logic                  sink_ready;
    logic [NUM_STAGES-1:0] first;
    logic [NUM_STAGES-1:0] windows;
    logic [NUM_STAGES-1:0] last;
    logic                  done;
    logic [3:0]            occupancy;
    logic                  busy;

    modport master (
        input  clk_ena,
        input  abort,
        input  start_req,
        input  sink_ready,
        output start_ack,
        output first,
        output windows,
        output last,
        output done,
        output occupancy,
        output busy
    );

    modport slave (
        output clk_ena,
        output abort,
        output start_req,
        output sink_ready,
        input  start_ack,
        input  first,
        input  windows,
        input  last,
        input  done,
        input  occupancy,
        input  busy
    );
endinterface

// File: rtl/sm_chain_sched.sv
// Sequencer for a chain of NUM_STAGES windowed processing stages.
//
// Each stage owns an active flag and a window counter. A block enters stage 0
// through the start_req/start_ack handshake, runs a window of MOD_COUNT+1
// enabled cycles in each stage, and moves to the next stage when that stage
// is at its terminal count and the downstream stage is free or emptying in
// the same cycle. The last stage hands off to the sink under sink_ready.
//
// Ports
//   clk   clock
//   rst   synchronous, active-high reset (wins over clk_ena)
//   bus   sm_chain_sched_if.master: clk_ena, abort, start_req, sink_ready in;
//         start_ack, first, windows, last, done, occupancy, busy out
//
// The bus interface must be instantiated with the same NUM_STAGES.
// first/last/windows/occupancy/busy are decoded from registers only;
// start_ack and done are combinational from the handshake inputs.
module sm_chain_sched #(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MOD_COUNT  = 14
) (
    input  logic             clk,
    input  logic             rst,
    sm_chain_sched_if.master bus
);

    localparam logic [WIDTH-1:0] ModCnt = WIDTH'(MOD_COUNT);

    logic [NUM_STAGES-1:0] act_q;
    logic [NUM_STAGES-1:0] act_d;
    logic [WIDTH-1:0]      cnt_q [NUM_STAGES];
    logic [WIDTH-1:0]      cnt_d [NUM_STAGES];

    logic [NUM_STAGES-1:0] first_v;
    logic [NUM_STAGES-1:0] last_v;
    logic [NUM_STAGES-1:0] adv;
    logic                  upd_ok;
    logic                  ack;
    logic [3:0]            occ;

    // Per-stage decode of the registered state.
    always_comb begin
        first_v = '0;
        last_v  = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            first_v[i] = act_q[i] & (cnt_q[i] == '0);
            last_v[i]  = act_q[i] & (cnt_q[i] == ModCnt);
        end
    end

    // Advance chain, walked from the sink back towards stage 0. `room` is
    // true when the place downstream of stage i can take a block this cycle:
    // either it is idle or it is itself handing its block on.
    always_comb begin
        logic room;
        adv  = '0;
        room = bus.sink_ready;
        for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
            adv[i] = last_v[i] & room;
            room   = ~act_q[i] | adv[i];
        end
    end

    assign upd_ok = bus.clk_ena & ~rst & ~bus.abort;
    assign ack    = bus.start_req & upd_ok & (~act_q[0] | adv[0]);

    // Next state. A load and an unload of the same stage in one cycle
    // resolve to load, so a stage can be refilled back-to-back.
    always_comb begin
        logic load;
        act_d = act_q;
        cnt_d = cnt_q;
        load  = ack;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (bus.abort) begin
                act_d[i] = 1'b0;
                cnt_d[i] = '0;
            end else if (load) begin
                act_d[i] = 1'b1;
                cnt_d[i] = '0;
            end else if (adv[i]) begin
                act_d[i] = 1'b0;
                cnt_d[i] = '0;
            end else if (act_q[i] && (cnt_q[i] != ModCnt)) begin
                cnt_d[i] = cnt_q[i] + WIDTH'(1);
            end
            // A stage at terminal count with no advance simply holds (stall).
            load = adv[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (bus.clk_ena) begin
            act_q <= act_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            occ = occ + 4'(act_q[i]);
        end
    end

    assign bus.start_ack = ack;
    assign bus.done      = adv[NUM_STAGES-1] & upd_ok;
    assign bus.first     = first_v;
    assign bus.windows   = act_q;
    assign bus.last      = last_v;
    assign bus.occupancy = occ;
    assign bus.busy      = |act_q;

endmodule

// File: tb/tb_sm_chain_sched.sv
// Directed bench for sm_chain_sched with NUM_STAGES=4, MOD_COUNT=3
// (window of 4 cycles per stage). Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_sm_chain_sched;

    localparam int unsigned N = 4;
    localparam int unsigned M = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sm_chain_sched_if #(.NUM_STAGES(N)) bus ();

    sm_chain_sched #(
        .NUM_STAGES(N),
        .WIDTH     (8),
        .MOD_COUNT (M)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit reached");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input int t,
                               input logic [3:0] ef, ew, el,
                               input logic ea, ed,
                               input logic [3:0] eo);
        chk($sformatf("%s t=%0d first", tag, t), 32'(bus.first), 32'(ef));
        chk($sformatf("%s t=%0d windows", tag, t), 32'(bus.windows), 32'(ew));
        chk($sformatf("%s t=%0d last", tag, t), 32'(bus.last), 32'(el));
        chk($sformatf("%s t=%0d start_ack", tag, t), 32'(bus.start_ack), 32'(ea));
        chk($sformatf("%s t=%0d done", tag, t), 32'(bus.done), 32'(ed));
        chk($sformatf("%s t=%0d occupancy", tag, t), 32'(bus.occupancy), 32'(eo));
        chk($sformatf("%s t=%0d busy", tag, t), 32'(bus.busy), 32'(eo != 4'd0));
    endtask

    // Single block acked at t=0: stage s active for t in 4s+1 .. 4s+4.
    function automatic void single_exp(input int t, output logic [3:0] f, w, l, o);
        int s;
        int k;
        if (t < 1 || t > 16) begin
            f = '0; w = '0; l = '0; o = '0;
        end else begin
            s = (t - 1) / 4;
            k = (t - 1) % 4;
            w = 4'(1 << s);
            f = (k == 0) ? w : 4'd0;
            l = (k == 3) ? w : 4'd0;
            o = 4'd1;
        end
    endfunction

    // start_req held high from an empty chain, sink always ready: acks every
    // 4 cycles, all active stages move in lockstep.
    function automatic void b2b_exp(input int t, output logic [3:0] f, w, l,
                                    output logic a, d, output logic [3:0] o);
        int nst;
        int k;
        if (t == 0) begin
            f = '0; w = '0; l = '0; o = '0; a = 1'b1; d = 1'b0;
        end else begin
            nst = (t - 1) / 4 + 1;
            if (nst > 4) nst = 4;
            k = (t - 1) % 4;
            w = 4'((1 << nst) - 1);
            f = (k == 0) ? w : 4'd0;
            l = (k == 3) ? w : 4'd0;
            o = 4'(nst);
            a = (t % 4 == 0);
            d = (t >= 16) && (t % 4 == 0);
        end
    endfunction

    task automatic apply_reset();
        cyc();
        rst            = 1'b1;
        bus.start_req  = 1'b0;
        bus.abort      = 1'b0;
        bus.clk_ena    = 1'b1;
        bus.sink_ready = 1'b1;
    endtask

    initial begin
        logic [3:0] ef, ew, el, eo;
        logic       ea, ed;
        int         tt;

        rst            = 1'b1;
        bus.clk_ena    = 1'b1;
        bus.abort      = 1'b0;
        bus.start_req  = 1'b1;
        bus.sink_ready = 1'b1;

        // Reset held with a pending request: never acked.
        for (int r = 0; r < 3; r++) begin
            cyc();
            rst           = 1'b1;
            bus.start_req = 1'b1;
            @(negedge clk);
            check_cycle("reset", r, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
        end

        // Single block, acked on the first cycle after reset drops.
        for (int t = 0; t <= 17; t++) begin
            cyc();
            rst           = 1'b0;
            bus.start_req = (t == 0);
            @(negedge clk);
            single_exp(t, ef, ew, el, eo);
            check_cycle("single", t, ef, ew, el, t == 0, t == 16, eo);
        end

        // Back-to-back blocks, sink always ready.
        for (int t = 0; t <= 24; t++) begin
            cyc();
            bus.start_req = 1'b1;
            @(negedge clk);
            b2b_exp(t, ef, ew, el, ea, ed, eo);
            check_cycle("b2b", t, ef, ew, el, ea, ed, eo);
        end

        // Backpressure: sink stalls 15..29, whole chain releases at 30.
        apply_reset();
        for (int t = 0; t <= 34; t++) begin
            cyc();
            rst            = 1'b0;
            bus.start_req  = 1'b1;
            bus.sink_ready = !(t >= 15 && t <= 29);
            @(negedge clk);
            if (t <= 15) begin
                b2b_exp(t, ef, ew, el, ea, ed, eo);
            end else if (t <= 29) begin
                b2b_exp(16, ef, ew, el, ea, ed, eo);
                ea = 1'b0;
                ed = 1'b0;
            end else begin
                b2b_exp(t - 14, ef, ew, el, ea, ed, eo);
            end
            check_cycle("stall", t, ef, ew, el, ea, ed, eo);
        end

        // Abort at 7 (two blocks in flight) and again at 12 (where an ack
        // would otherwise land); the chain restarts from empty each time.
        apply_reset();
        for (int t = 0; t <= 18; t++) begin
            cyc();
            rst           = 1'b0;
            bus.start_req = 1'b1;
            bus.abort     = (t == 7) || (t == 12);
            @(negedge clk);
            tt = (t <= 7) ? t : ((t <= 12) ? t - 8 : t - 13);
            b2b_exp(tt, ef, ew, el, ea, ed, eo);
            if (bus.abort) begin
                ea = 1'b0;
                ed = 1'b0;
            end
            check_cycle("abort", t, ef, ew, el, ea, ed, eo);
        end

        // Reset clears state even while clk_ena is low.
        cyc();
        bus.abort   = 1'b0;
        rst         = 1'b1;
        bus.clk_ena = 1'b0;
        @(negedge clk);
        b2b_exp(6, ef, ew, el, ea, ed, eo);
        check_cycle("rst_noena", 0, ef, ew, el, 1'b0, 1'b0, eo);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check_cycle("rst_noena", 1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
        cyc();
        bus.clk_ena = 1'b1;
        @(negedge clk);
        check_cycle("rst_noena", 2, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0);

        // clk_ena alternating: the single-block timeline at half rate; the
        // request also stays high on the disabled cycle after the ack.
        apply_reset();
        for (int t = 0; t <= 34; t++) begin
            cyc();
            rst           = 1'b0;
            bus.clk_ena   = (t % 2 == 0);
            bus.start_req = (t <= 1);
            @(negedge clk);
            single_exp((t + 1) / 2, ef, ew, el, eo);
            check_cycle("ena_half", t, ef, ew, el, t == 0, t == 32, eo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
